// File: rtl/my_and_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : my_and_pkg
//  Description : Shared definitions for the branch-decision gate: default
//                statistics counter width and the branch-taken function.
//  Revision    : 1.0 - initial release
// ============================================================================
package my_and_pkg;

    // Default width of the branch statistics counters.
    localparam int c_CNT_W_DEFAULT = 16;

    // Branch is taken when the instruction is a branch and the ALU reports
    // equal operands. A plain '&' is kept so X/Z propagate with normal
    // Verilog semantics (0 dominates, otherwise X).
    function automatic logic branch_taken(input logic branch, input logic zero);
        return branch & zero;
    endfunction

endpackage : my_and_pkg
`default_nettype wire

// File: rtl/my_and_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : CNT_W-bit up counter with enable that stops at its maximum
//                value instead of wrapping. Asynchronous active-high reset.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous reset, active high
//                i_en     - increment request for this edge
//                o_count  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import my_and_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == c_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && !w_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/my_and.sv
`default_nettype none
// ============================================================================
//  Module      : my_and
//  Description : Branch-decision gate of the single-cycle MIPS datapath.
//                PcSrc = Branch & zero selects PC+4+offset at the PC mux.
//                Also provides a registered copy of the decision and
//                saturating branch / taken statistics counters.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active high
//                Branch     - current instruction is a branch (beq)
//                zero       - ALU result is zero
//                PcSrc      - branch taken (combinational, zero latency)
//                PcSrc_q    - PcSrc registered on clk
//                branch_cnt - cycles with Branch=1 since reset (saturating)
//                taken_cnt  - cycles with PcSrc=1 since reset (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module my_and
    import my_and_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Branch,
    input  logic             zero,
    output logic             PcSrc,
    output logic             PcSrc_q,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic w_pcsrc;
    logic r_pcsrc_q;

    // Decision is purely combinational: independent of clk and rst so the
    // PC mux sees it in the same cycle, even while reset is held.
    assign w_pcsrc = branch_taken(Branch, zero);
    assign PcSrc   = w_pcsrc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcsrc_q <= 1'b0;
        end else begin
            r_pcsrc_q <= w_pcsrc;
        end
    end

    assign PcSrc_q = r_pcsrc_q;

    // Both counters share clock and reset, and taken implies branch, so
    // taken_cnt can never overtake branch_cnt (both saturate at the same max).
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_branch_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (Branch),
        .o_count (branch_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_taken_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_pcsrc),
        .o_count (taken_cnt)
    );

endmodule : my_and
`default_nettype wire

// File: tb/tb_my_and.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_and
//  Description : Self-checking bench for my_and. Two instances (CNT_W=16 and
//                CNT_W=3) share the same stimulus; expected registered values
//                come from a bench-side model through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_and;

    localparam int c_W16 = 16;
    localparam int c_W3  = 3;

    logic             clk;
    logic             clk_en;
    logic             rst;
    logic             Branch;
    logic             zero;

    logic             pcsrc16, pcsrc_q16;
    logic [c_W16-1:0] bcnt16, tcnt16;
    logic             pcsrc3, pcsrc_q3;
    logic [c_W3-1:0]  bcnt3, tcnt3;

    int total = 0;
    int bad   = 0;

    // bench-side model state
    int m_q;
    int m_b16, m_t16, m_b3, m_t3;

    typedef struct {
        int q;
        int b16;
        int t16;
        int b3;
        int t3;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic b;
        logic z;
        logic exp_pcsrc;
    } vec_t;

    my_and #(.CNT_W(c_W16)) dut (
        .clk        (clk),
        .rst        (rst),
        .Branch     (Branch),
        .zero       (zero),
        .PcSrc      (pcsrc16),
        .PcSrc_q    (pcsrc_q16),
        .branch_cnt (bcnt16),
        .taken_cnt  (tcnt16)
    );

    my_and #(.CNT_W(c_W3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .Branch     (Branch),
        .zero       (zero),
        .PcSrc      (pcsrc3),
        .PcSrc_q    (pcsrc_q3),
        .branch_cnt (bcnt3),
        .taken_cnt  (tcnt3)
    );

    // Clock only toggles when enabled, so the first test runs with no clock.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic model_reset();
        m_q = 0; m_b16 = 0; m_t16 = 0; m_b3 = 0; m_t3 = 0;
    endtask

    // Drive one cycle: inputs are applied 1 ns after an edge, the combinational
    // output is checked, the model predicts the post-edge state, and the
    // scoreboard entry is compared 1 ns after the next rising edge.
    task automatic cycle(input logic b, input logic z);
        exp_t e;
        exp_t got;
        int   p;
        Branch = b;
        zero   = z;
        #1;
        p = (b & z) ? 1 : 0;
        check("pcsrc16", int'(pcsrc16), p);
        check("pcsrc3", int'(pcsrc3), p);
        m_q = p;
        if (b) begin
            m_b16 = sat(m_b16, c_W16);
            m_b3  = sat(m_b3, c_W3);
        end
        if (p != 0) begin
            m_t16 = sat(m_t16, c_W16);
            m_t3  = sat(m_t3, c_W3);
        end
        e.q = m_q; e.b16 = m_b16; e.t16 = m_t16; e.b3 = m_b3; e.t3 = m_t3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("pcsrc_q16", int'(pcsrc_q16), got.q);
        check("pcsrc_q3", int'(pcsrc_q3), got.q);
        check("branch_cnt16", int'(bcnt16), got.b16);
        check("taken_cnt16", int'(tcnt16), got.t16);
        check("branch_cnt3", int'(bcnt3), got.b3);
        check("taken_cnt3", int'(tcnt3), got.t3);
        check("invariant16", int'(tcnt16 <= bcnt16), 1);
        check("invariant3", int'(tcnt3 <= bcnt3), 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        check("rst_pcsrc_q", int'(pcsrc_q16), 0);
        check("rst_branch_cnt", int'(bcnt16), 0);
        check("rst_taken_cnt", int'(tcnt16), 0);
        check("rst_branch_cnt3", int'(bcnt3), 0);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t vecs[4];

    initial begin
        clk_en = 1'b0;
        rst    = 1'b0;
        Branch = 1'b0;
        zero   = 1'b0;
        model_reset();

        // ---- 1: combinational truth table, no clock ----
        vecs[0] = '{b: 1'b0, z: 1'b0, exp_pcsrc: 1'b0};
        vecs[1] = '{b: 1'b0, z: 1'b1, exp_pcsrc: 1'b0};
        vecs[2] = '{b: 1'b1, z: 1'b0, exp_pcsrc: 1'b0};
        vecs[3] = '{b: 1'b1, z: 1'b1, exp_pcsrc: 1'b1};
        for (int i = 0; i < 4; i++) begin
            Branch = vecs[i].b;
            zero   = vecs[i].z;
            #1;
            check($sformatf("tt%0d_pcsrc16", i), int'(pcsrc16), int'(vecs[i].exp_pcsrc));
            check($sformatf("tt%0d_pcsrc3", i), int'(pcsrc3), int'(vecs[i].exp_pcsrc));
            #9;
        end

        // ---- 2: unknown inputs, then a known taken branch ----
        Branch = 1'bx;
        zero   = 1'bx;
        #200;
        Branch = 1'b0;
        #1;
        check("x_branch0", int'(pcsrc16), 0);
        Branch = 1'b1;
        zero   = 1'b1;
        #1;
        check("x_then_11", int'(pcsrc16), 1);
        Branch = 1'b0;
        #1;
        check("x_then_b0", int'(pcsrc16), 0);

        // reset while held: PcSrc still combinational
        rst    = 1'b1;
        Branch = 1'b1;
        zero   = 1'b1;
        #1;
        check("pcsrc_during_rst", int'(pcsrc16), 1);
        check("rst_async_noclk_q", int'(pcsrc_q16), 0);
        check("rst_async_noclk_cnt", int'(bcnt16), 0);
        Branch = 1'b0;
        rst    = 1'b0;

        // ---- 3: clocked sequence, 3 taken then 2 not taken ----
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        check("seq_q_after_taken", int'(pcsrc_q16), 1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
        check("seq_branch_cnt", int'(bcnt16), 5);
        check("seq_taken_cnt", int'(tcnt16), 3);
        check("seq_q_after_fall", int'(pcsrc_q16), 0);

        // ---- 4: async reset between edges with nonzero counters ----
        cycle(1'b1, 1'b1);
        Branch = 1'b1;
        zero   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_q", int'(pcsrc_q16), 0);
        check("mid_rst_bcnt", int'(bcnt16), 0);
        check("mid_rst_tcnt", int'(tcnt16), 0);
        check("mid_rst_pcsrc", int'(pcsrc16), 1);
        zero = 1'b0;
        #1;
        check("mid_rst_pcsrc_track", int'(pcsrc16), 0);
        zero = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_q", int'(pcsrc_q16), 0);
        check("rst_hold_bcnt", int'(bcnt16), 0);
        check("rst_hold_tcnt", int'(tcnt16), 0);
        rst = 1'b0;
        model_reset();

        // ---- 5: saturation of the 3-bit instance ----
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
        check("sat3_branch", int'(bcnt3), 7);
        check("sat3_taken", int'(tcnt3), 7);
        check("wide_branch", int'(bcnt16), 10);
        check("wide_taken", int'(tcnt16), 10);

        // ---- 6: random stimulus against the model ----
        pulse_reset();
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_my_and
`default_nettype wire
